// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port register file.
package regfile_pkg;

  localparam int unsigned REG_DATA_W    = 16;
  localparam int unsigned REG_DEPTH     = 8;
  localparam int unsigned REG_RESET_VAL = 0;

endpackage : regfile_pkg

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: flush beats set, set beats write-clear.
module regfile_scoreboard #(
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DEPTH-1:0] set,
  input  logic [DEPTH-1:0] clear,
  input  logic             flush,
  output logic [DEPTH-1:0] busy_vec
);

  logic [DEPTH-1:0] r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else if (flush) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~clear) | set;
    end
  end

  assign busy_vec = r_busy;

endmodule : regfile_scoreboard

// File: rtl/regfile_mp.sv
// Two-read/one-write register file with write bypass and busy scoreboard.
// REGFILE_ZERO_REG_EN hardwires register 0 to zero and never busy.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = REG_DATA_W,
  parameter int unsigned DEPTH  = REG_DEPTH,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  output logic              rd_busy_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_b,
  input  logic              busy_set,
  input  logic [ADDR_W-1:0] busy_addr,
  input  logic              flush,
  output logic [DEPTH-1:0]  busy_vec
);

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_wr_ok;
  logic              w_set_ok;
  logic [DEPTH-1:0]  w_set_vec;
  logic [DEPTH-1:0]  w_clr_vec;
  logic              w_byp_a;
  logic              w_byp_b;
  logic              w_zero_a;
  logic              w_zero_b;

  assign w_wr_ok   = wr_en && !(ZERO_REG && (wr_addr == '0));
  assign w_set_ok  = busy_set && !(ZERO_REG && (busy_addr == '0));
  assign w_clr_vec = w_wr_ok  ? (DEPTH'(1) << wr_addr)   : '0;
  assign w_set_vec = w_set_ok ? (DEPTH'(1) << busy_addr) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= DATA_W'(REG_RESET_VAL);
      end
    end else if (w_wr_ok) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  regfile_scoreboard #(
    .DEPTH (DEPTH)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set      (w_set_vec),
    .clear    (w_clr_vec),
    .flush    (flush),
    .busy_vec (busy_vec)
  );

  // Bypass is gated by rst_n so the outputs read zero while reset is held.
  assign w_byp_a  = rst_n && w_wr_ok && (rd_addr_a == wr_addr);
  assign w_byp_b  = rst_n && w_wr_ok && (rd_addr_b == wr_addr);
  assign w_zero_a = ZERO_REG && (rd_addr_a == '0);
  assign w_zero_b = ZERO_REG && (rd_addr_b == '0);

  assign rd_data_a = w_zero_a ? '0 : (w_byp_a ? wr_data : r_mem[rd_addr_a]);
  assign rd_data_b = w_zero_b ? '0 : (w_byp_b ? wr_data : r_mem[rd_addr_b]);
  assign rd_busy_a = !w_byp_a && busy_vec[rd_addr_a];
  assign rd_busy_b = !w_byp_b && busy_vec[rd_addr_b];

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// Randomized bench for regfile_mp against an array-based reference model.
module tb_regfile_mp;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [2:0]  rd_addr_a;
  logic [15:0] rd_data_a;
  logic        rd_busy_a;
  logic [2:0]  rd_addr_b;
  logic [15:0] rd_data_b;
  logic        rd_busy_b;
  logic        busy_set;
  logic [2:0]  busy_addr;
  logic        flush;
  logic [7:0]  busy_vec;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] m_mem  [8];
  bit          m_busy [8];

  always #5 clk = ~clk;

  regfile_mp dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (rd_data_a),
    .rd_busy_a (rd_busy_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (rd_data_b),
    .rd_busy_b (rd_busy_b),
    .busy_set  (busy_set),
    .busy_addr (busy_addr),
    .flush     (flush),
    .busy_vec  (busy_vec)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_mem[i]  = 16'h0;
      m_busy[i] = 1'b0;
    end
  endtask

  // What a reader of register a should see this cycle.
  task automatic expect_read(input logic [2:0] a, output logic [15:0] d, output bit b);
    if (!rst_n || (ZR && a == 3'd0)) begin
      d = 16'h0;
      b = 1'b0;
    end else if (wr_en && a == wr_addr) begin
      d = wr_data;
      b = 1'b0;
    end else begin
      d = m_mem[a];
      b = m_busy[a];
    end
  endtask

  task automatic check_all(input string t);
    logic [15:0] ed;
    bit          eb;
    logic [7:0]  ev;
    expect_read(rd_addr_a, ed, eb);
    check({t, ":rda"}, 32'(rd_data_a), 32'(ed));
    check({t, ":bsa"}, 32'(rd_busy_a), 32'(eb));
    expect_read(rd_addr_b, ed, eb);
    check({t, ":rdb"}, 32'(rd_data_b), 32'(ed));
    check({t, ":bsb"}, 32'(rd_busy_b), 32'(eb));
    for (int i = 0; i < 8; i++) ev[i] = m_busy[i];
    check({t, ":vec"}, 32'(busy_vec), 32'(ev));
  endtask

  // Apply the clock-edge rules to the model: flush > set > write-clear.
  task automatic model_edge();
    if (!rst_n) return;
    if (wr_en && !(ZR && wr_addr == 3'd0)) begin
      m_mem[wr_addr]  = wr_data;
      m_busy[wr_addr] = 1'b0;
    end
    if (busy_set && !(ZR && busy_addr == 3'd0)) m_busy[busy_addr] = 1'b1;
    if (flush) for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
  endtask

  task automatic drive(input bit we, input logic [2:0] wa, input logic [15:0] wd,
                       input logic [2:0] ra, input logic [2:0] rb,
                       input bit bs, input logic [2:0] ba, input bit fl);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_addr_a = ra; rd_addr_b = rb;
    busy_set = bs; busy_addr = ba; flush = fl;
  endtask

  // One cycle: drive at negedge, check mid-cycle, update model at posedge.
  task automatic cyc(input string t, input bit we, input logic [2:0] wa, input logic [15:0] wd,
                     input logic [2:0] ra, input logic [2:0] rb,
                     input bit bs, input logic [2:0] ba, input bit fl);
    @(negedge clk);
    drive(we, wa, wd, ra, rb, bs, ba, fl);
    #1;
    check_all(t);
    @(posedge clk);
    model_edge();
  endtask

  initial begin
    rst_n = 1'b0;
    model_reset();
    drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
    // Reset held: every address reads zero even with a live write present.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(1'b1, 3'(i), 16'hFFFF, 3'(i), 3'(7 - i), 1'b1, 3'(i), 1'b0);
      #1;
      check("rst_rda", 32'(rd_data_a), 32'h0);
      check("rst_rdb", 32'(rd_data_b), 32'h0);
      check("rst_bsa", 32'(rd_busy_a), 32'h0);
      check("rst_vec", 32'(busy_vec), 32'h0);
    end
    @(negedge clk);
    drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
    rst_n = 1'b1;

    cyc("wr3", 1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd3, 1'b0, 3'd0, 1'b0);
    check("wr3_byp", 32'(rd_data_a), 32'hBEEF);
    cyc("rd3", 1'b0, 3'd0, 16'h0, 3'd3, 3'd3, 1'b0, 3'd0, 1'b0);
    check("rd3_a", 32'(rd_data_a), 32'hBEEF);
    check("rd3_b", 32'(rd_data_b), 32'hBEEF);

    cyc("set5", 1'b0, 3'd0, 16'h0, 3'd5, 3'd5, 1'b1, 3'd5, 1'b0);
    cyc("bsy5", 1'b0, 3'd0, 16'h0, 3'd5, 3'd5, 1'b0, 3'd0, 1'b0);
    check("bsy5_vec", 32'(busy_vec), 32'h20);
    check("bsy5_a", 32'(rd_busy_a), 32'h1);
    cyc("wr5", 1'b1, 3'd5, 16'h1234, 3'd5, 3'd5, 1'b0, 3'd0, 1'b0);
    check("wr5_bsa", 32'(rd_busy_a), 32'h0);
    check("wr5_rda", 32'(rd_data_a), 32'h1234);
    cyc("clr5", 1'b0, 3'd0, 16'h0, 3'd5, 3'd2, 1'b0, 3'd0, 1'b0);
    check("clr5_vec", 32'(busy_vec), 32'h00);

    cyc("sw2", 1'b1, 3'd2, 16'h00AA, 3'd2, 3'd3, 1'b1, 3'd2, 1'b0);
    cyc("rd2", 1'b0, 3'd0, 16'h0, 3'd2, 3'd2, 1'b0, 3'd0, 1'b0);
    check("rd2_dat", 32'(rd_data_a), 32'h00AA);
    check("rd2_bsy", 32'(busy_vec[2]), 32'h1);

    cyc("s1", 1'b0, 3'd0, 16'h0, 3'd1, 3'd4, 1'b1, 3'd1, 1'b0);
    cyc("s4", 1'b0, 3'd0, 16'h0, 3'd1, 3'd4, 1'b1, 3'd4, 1'b0);
    cyc("s6", 1'b0, 3'd0, 16'h0, 3'd1, 3'd4, 1'b1, 3'd6, 1'b0);
    cyc("fl7", 1'b0, 3'd0, 16'h0, 3'd6, 3'd7, 1'b1, 3'd7, 1'b1);
    cyc("pfl", 1'b0, 3'd0, 16'h0, 3'd7, 3'd6, 1'b0, 3'd0, 1'b0);
    check("pfl_vec", 32'(busy_vec), 32'h00);

    cyc("w0", 1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd0, 1'b1, 3'd0, 1'b0);
    cyc("r0", 1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
    if (ZR) begin
      check("r0_dat", 32'(rd_data_a), 32'h0000);
      check("r0_bsy", 32'(busy_vec[0]), 32'h0);
    end else begin
      check("r0_dat", 32'(rd_data_a), 32'hFFFF);
      check("r0_bsy", 32'(busy_vec[0]), 32'h1);
    end

    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        // Asynchronous reset mid-cycle with a write and set in flight.
        @(negedge clk);
        drive(1'b1, 3'($urandom_range(7)), 16'($urandom), 3'($urandom_range(7)),
              3'($urandom_range(7)), 1'b1, 3'($urandom_range(7)), 1'b0);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("arst");
        @(posedge clk);
        @(negedge clk);
        check_all("arst_hold");
        drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
        rst_n = 1'b1;
      end
      cyc("rnd", 1'($urandom_range(1)), 3'($urandom_range(7)), 16'($urandom),
          3'($urandom_range(7)), 3'($urandom_range(7)),
          1'($urandom_range(1)), 3'($urandom_range(7)), ($urandom_range(15) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_regfile_mp

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the 16-bit processor core, replacing the fixed 8×16 two-read/one-write array. It adds an asynchronous active-low reset, a write-to-read bypass, and a per-register busy scoreboard that decode uses to detect read-after-write hazards on in-flight results. It sits between decode (reads, busy set) and writeback (writes, busy clear).

## Interface
- DATA_W, 16, register width in bits
- DEPTH, 8, number of registers; a power of two, at least 2
- ADDR_W, $clog2(DEPTH), register address width
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write enable
- wr_addr  in  ADDR_W  write destination
- wr_data  in  DATA_W  write data
- rd_addr_a  in  ADDR_W  read port A address
- rd_data_a  out  DATA_W  read port A data
- rd_busy_a  out  1  register at rd_addr_a has a pending write
- rd_addr_b  in  ADDR_W  read port B address
- rd_data_b  out  DATA_W  read port B data
- rd_busy_b  out  1  register at rd_addr_b has a pending write
- busy_set  in  1  mark busy_addr as pending (instruction issued)
- busy_addr  in  ADDR_W  register to mark
- flush  in  1  clear all busy bits (pipeline flush)
- busy_vec  out  DEPTH  current busy bits, bit i = register i

## Operation
- Storage: DEPTH × DATA_W array plus DEPTH busy bits.
- Write: on the rising clk edge with wr_en=1, reg[wr_addr] <= wr_data and busy[wr_addr] <= 0.
- Read: combinational. If wr_en=1 and rd_addr == wr_addr, rd_data = wr_data (bypass). Otherwise rd_data = reg[rd_addr].
- rd_busy: combinational busy[rd_addr]. It is forced to 0 when a bypassing write to that address is present in the same cycle.
- busy_set=1: busy[busy_addr] <= 1 at the next edge.
- Priority per busy bit at an edge: flush > busy_set > write-clear.
  - busy_set and a write to the same address in the same cycle leave the bit at 1, because a new producer has issued.
  - flush clears every bit and drops that cycle's busy_set. A write in a flush cycle still updates data.
- Both read ports may address the same register; each returns identical data and busy.
- Address arithmetic is unsigned. Out-of-range addresses cannot occur because DEPTH = 2^ADDR_W.

## Timing
- Reset (rst_n=0, asynchronous):
  - all registers are 0 and all busy bits are 0;
  - rd_data_a/b are 0, rd_busy_a/b are 0, busy_vec is 0 while held.
- Release of reset is synchronous to clk. The first write can land on the first edge with rst_n=1.
- Write latency is one edge to the array. Bypass gives effective zero-cycle read-after-write visibility.
- Busy set is visible on rd_busy one cycle after busy_set. Busy clear takes effect at the same edge that stores the data.
- Reset asserted mid-operation discards any in-flight write or set in that cycle.

## Configuration
- REGFILE_ZERO_REG_EN defined: register 0 is hardwired.
  - Reads of address 0 return 0, including during bypass.
  - Writes and busy_set to address 0 are ignored.
  - busy_vec[0] and rd_busy for address 0 are always 0.
- Undefined: register 0 is an ordinary register with full read, write, bypass and busy behaviour.

## Structure
- Package regfile_pkg holds:
  - default DATA_W/DEPTH constants;
  - the reset value constant REG_RESET_VAL = 0.
- One sub-module, regfile_scoreboard, owns the busy bits.
  - Inputs: set, clear, flush.
  - Outputs: busy_vec.
  - The data array and read muxes stay in regfile_mp.

## Test plan
- Reset then read all 8 addresses on both ports -> data 0x0000, busy 0, busy_vec 8'h00.
- Write 0xBEEF to r3, then read r3 on A and B in the next cycle -> both 0xBEEF. Reading r3 in the write cycle itself -> 0xBEEF via bypass.
- busy_set r5 -> busy_vec 8'h20 next cycle, rd_busy_a=1 at addr 5. Write 0x1234 to r5 -> in that cycle rd_busy_a=0 and rd_data_a=0x1234; busy_vec 8'h00 after the edge.
- Same cycle: busy_set r2 and write 0x00AA to r2 -> r2=0x00AA, busy_vec[2]=1.
- busy_set r1, r4, r6 over three cycles, then flush with busy_set r7 -> busy_vec 8'h00 after the edge.
- With REGFILE_ZERO_REG_EN: write 0xFFFF to r0 and busy_set r0 -> r0 reads 0x0000, busy 0. Without the macro: r0 reads 0xFFFF and busy_vec[0]=1.
